d_mem_checker: RTL and testbench

- Reader-side consumer of the decrypted-message RAM (d_mem) that the decryption stage fills.
- After decryption completes, the parent controller starts this block. It reads d_mem bytes sequentially and classifies each as legal plaintext: lowercase a–z (8'h61–8'h7A) or space (8'h20).
- It reports pass/fail, plus the first offending address, so a key-search controller can accept the current secret_key or advance it.
- It uses the same level-held start_flag / done_flag handshake as the other memory sub-blocks.

---
 rtl/d_mem_checker_if.sv | 19 +
 rtl/d_mem_checker.sv | 112 +++++++++++
 tb/tb_d_mem_checker.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d_mem_checker_if.sv
// d_mem read port seen by the checker.
// The checker drives address and write enable; the RAM returns q.
interface d_mem_checker_if;
  logic [7:0] d_mem_addr;
  logic [7:0] d_mem_data_out;
  logic       d_mem_write;

  modport master (
    output d_mem_addr,
    output d_mem_write,
    input  d_mem_data_out
  );

  modport slave (
    input  d_mem_addr,
    input  d_mem_write,
    output d_mem_data_out
  );
endinterface

// File: rtl/d_mem_checker.sv
// Scans decrypted d_mem bytes for plaintext (a-z or space).
// Reports pass/fail, first bad address and count of good bytes.
module d_mem_checker #(
  parameter int MSG_LEN   = 32,
  parameter int READ_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_flag,
  d_mem_checker_if.master        mem,
  output logic                   done_flag,
  output logic                   valid,
  output logic [7:0]             fail_index,
  output logic [8:0]             bytes_checked
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [8:0] LAST      = 9'(MSG_LEN - 1);
  localparam logic [1:0] WAIT_LAST = 2'(READ_WAIT - 1);

  state_t     state;
  logic [1:0] wait_cnt;
  logic       legal;
  logic [7:0] q;

  assign q     = mem.d_mem_data_out;
  assign legal = (q >= 8'h61 && q <= 8'h7A) || (q == 8'h20);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= 2'd0;
      mem.d_mem_addr <= 8'd0;
      mem.d_mem_write <= 1'b0;
      done_flag      <= 1'b0;
      valid          <= 1'b0;
      fail_index     <= 8'd0;
      bytes_checked  <= 9'd0;
    end else begin
      mem.d_mem_write <= 1'b0;
      unique case (state)
        IDLE: begin
          done_flag <= 1'b0;
          if (start_flag) begin
            state          <= READ;
            wait_cnt       <= 2'd0;
            mem.d_mem_addr <= 8'd0;
            valid          <= 1'b0;
            fail_index     <= 8'd0;
            bytes_checked  <= 9'd0;
          end
        end
        READ: begin
          if (!start_flag) begin
            state <= IDLE;
          end else if (READ_WAIT > 1) begin
            state    <= WAIT;
            wait_cnt <= 2'd1;
          end else begin
            state <= CHECK;
          end
        end
        WAIT: begin
          if (!start_flag) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= CHECK;
            wait_cnt <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        CHECK: begin
          if (!start_flag) begin
            state <= IDLE;
          end else if (!legal) begin
            state      <= DONE;
            done_flag  <= 1'b1;
            valid      <= 1'b0;
            fail_index <= mem.d_mem_addr;
          end else if ({1'b0, mem.d_mem_addr} == LAST) begin
            // 9-bit compare so MSG_LEN=256 ends at 8'hFF without wrapping
            state         <= DONE;
            done_flag     <= 1'b1;
            valid         <= 1'b1;
            fail_index    <= 8'd0;
            bytes_checked <= bytes_checked + 9'd1;
          end else begin
            state          <= READ;
            mem.d_mem_addr <= mem.d_mem_addr + 8'd1;
            bytes_checked  <= bytes_checked + 9'd1;
          end
        end
        DONE: begin
          if (!start_flag) begin
            state     <= IDLE;
            done_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_checker.sv
// Scoreboard bench for d_mem_checker: directed messages, queued expectations.
// Two instances: default size and MSG_LEN=256 / READ_WAIT=1.
module tb_d_mem_checker;

  typedef struct {
    logic       valid;
    logic [7:0] fail;
    logic [8:0] bytes;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic       done_a, valid_a, done_b, valid_b;
  logic [7:0] fail_a, fail_b;
  logic [8:0] bytes_a, bytes_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] q1_a;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0_a = 0;
  int t0_b = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int wr_hits = 0;
  int max_addr_a = 0;
  int max_addr_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  d_mem_checker_if bus_a();
  d_mem_checker_if bus_b();

  d_mem_checker #(.MSG_LEN(32), .READ_WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .start_flag(start_a), .mem(bus_a),
    .done_flag(done_a), .valid(valid_a),
    .fail_index(fail_a), .bytes_checked(bytes_a)
  );

  d_mem_checker #(.MSG_LEN(256), .READ_WAIT(1)) dut_b (
    .clk(clk), .reset(reset), .start_flag(start_b), .mem(bus_b),
    .done_flag(done_b), .valid(valid_b),
    .fail_index(fail_b), .bytes_checked(bytes_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q1_a <= mem_a[bus_a.d_mem_addr];
    bus_a.d_mem_data_out <= q1_a;
    bus_b.d_mem_data_out <= mem_b[bus_b.d_mem_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_done(string tag, logic v, logic [7:0] f,
                            logic [8:0] b, int lat, exp_t e);
    cmp({tag, "_valid"}, v, e.valid);
    cmp({tag, "_fail_index"}, f, e.fail);
    cmp({tag, "_bytes"}, b, e.bytes);
    cmp({tag, "_latency"}, lat, e.lat);
  endtask

  // monitors: pop an expectation on each rising done_flag
  initial begin
    logic prev_a, prev_b;
    exp_t e;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (done_a && !prev_a) begin
        done_cnt_a++;
        if (q_a.size() == 0) cmp("unexpected_done_a", 1, 0);
        else begin
          e = q_a.pop_front();
          check_done("a", valid_a, fail_a, bytes_a, cyc - t0_a, e);
        end
      end
      if (done_b && !prev_b) begin
        done_cnt_b++;
        if (q_b.size() == 0) cmp("unexpected_done_b", 1, 0);
        else begin
          e = q_b.pop_front();
          check_done("b", valid_b, fail_b, bytes_b, cyc - t0_b, e);
        end
      end
      prev_a = done_a;
      prev_b = done_b;
      if (bus_a.d_mem_write || bus_b.d_mem_write) wr_hits++;
      if (start_a && int'(bus_a.d_mem_addr) > max_addr_a)
        max_addr_a = int'(bus_a.d_mem_addr);
      if (start_b && int'(bus_b.d_mem_addr) > max_addr_b)
        max_addr_b = int'(bus_b.d_mem_addr);
    end
  end

  task automatic load_msg();
    string s;
    s = "attack at dawn and hold the line";
    for (int i = 0; i < 32; i++) mem_a[i] = s[i];
  endtask

  task automatic wait_done_a(int budget);
    for (int i = 0; i < budget && !done_a; i++) @(negedge clk);
    if (!done_a) begin
      cmp("timeout_a", 0, 1);
      q_a.delete();
    end
  endtask

  task automatic run_a(logic v, logic [7:0] f, logic [8:0] b, int lat);
    exp_t e;
    e.valid = v;
    e.fail  = f;
    e.bytes = b;
    e.lat   = lat;
    q_a.push_back(e);
    @(negedge clk);
    max_addr_a = 0;
    start_a = 1'b1;
    t0_a = cyc;
    wait_done_a(400);
    start_a = 1'b0;
    @(negedge clk);
    cmp("done_drop_a", done_a, 0);
  endtask

  task automatic check_zero(string tag);
    cmp({tag, "_addr"}, bus_a.d_mem_addr, 0);
    cmp({tag, "_done"}, done_a, 0);
    cmp({tag, "_valid"}, valid_a, 0);
    cmp({tag, "_fail_index"}, fail_a, 0);
    cmp({tag, "_bytes"}, bytes_a, 0);
    cmp({tag, "_write"}, bus_a.d_mem_write, 0);
  endtask

  initial begin
    exp_t e;
    int n;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    load_msg();
    run_a(1'b1, 8'd0, 9'd32, 97);

    mem_a[5] = 8'h41;
    run_a(1'b0, 8'd5, 9'd5, 19);
    cmp("max_addr_mid_fail", max_addr_a, 5);

    load_msg();
    mem_a[0] = 8'h20;
    mem_a[1] = 8'h61;
    mem_a[2] = 8'h7A;
    mem_a[3] = 8'h7B;
    run_a(1'b0, 8'd3, 9'd3, 13);
    mem_a[0] = 8'h60;
    run_a(1'b0, 8'd0, 9'd0, 4);
    mem_a[0] = 8'h1F;
    run_a(1'b0, 8'd0, 9'd0, 4);
    mem_a[0] = 8'h21;
    run_a(1'b0, 8'd0, 9'd0, 4);

    load_msg();
    mem_a[31] = 8'h41;
    run_a(1'b0, 8'd31, 9'd31, 97);

    // abort by dropping start partway, then rerun from address 0
    load_msg();
    n = done_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    t0_a = cyc;
    while (cyc - t0_a < 10) @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    cmp("abort_no_done", done_cnt_a, n);
    cmp("abort_valid", valid_a, 0);
    run_a(1'b1, 8'd0, 9'd32, 97);

    // asynchronous reset mid-run, release with start held
    @(negedge clk);
    start_a = 1'b1;
    t0_a = cyc;
    while (cyc - t0_a < 40) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    e.valid = 1'b1;
    e.fail  = 8'd0;
    e.bytes = 9'd32;
    e.lat   = 97;
    q_a.push_back(e);
    reset = 1'b0;
    t0_a = cyc;
    wait_done_a(400);
    start_a = 1'b0;
    @(negedge clk);

    // max length instance
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h20;
    e.valid = 1'b1;
    e.fail  = 8'd0;
    e.bytes = 9'd256;
    e.lat   = 513;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b1;
    t0_b = cyc;
    for (int i = 0; i < 1000 && !done_b; i++) @(negedge clk);
    if (!done_b) begin
      cmp("timeout_b", 0, 1);
      q_b.delete();
    end
    cmp("max_addr_b", max_addr_b, 255);
    start_b = 1'b0;
    @(negedge clk);
    cmp("done_drop_b", done_b, 0);

    cmp("d_mem_write_hits", wr_hits, 0);
    cmp("pending_a", q_a.size(), 0);
    cmp("pending_b", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
